// File: rtl/serial_adder_sequencer.sv
// Bit-serial adder front end: accepts two operands plus carry-in, adds them one bit
// pair per clock LSB first through a single full-adder slice, and returns sum/cout/overflow.
module serial_adder_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             s_bit_s;
    logic             c_bit_s;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = SHIFT;
                else          state_d = IDLE;
            end
            SHIFT: begin
                if (bitcnt_q == LAST_BIT) state_d = DONE;
                else                      state_d = SHIFT;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
                else           state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Full-adder slice on the current LSB pair and the held carry
    always_comb begin
        s_bit_s = opa_q[0] ^ opb_q[0] ^ carry_q;
        c_bit_s = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    end

    // Datapath next values; everything holds unless accepting or shifting
    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        sum_d    = sum_q;
        bitcnt_d = bitcnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d    = a;
                    opb_d    = b;
                    carry_d  = cin;
                    bitcnt_d = '0;
                    sum_d    = '0;
                end else begin
                    opa_d = opa_q;
                end
            end
            SHIFT: begin
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = s_bit_s;
                opa_d            = opa_q >> 1;
                opb_d            = opb_q >> 1;
                carry_d          = c_bit_s;
                bitcnt_d         = bitcnt_q + CW'(1);
                // On the MSB edge carry_q is the carry into the MSB
                if (bitcnt_q == LAST_BIT) begin
                    cout_d = c_bit_s;
                    ovf_d  = carry_q ^ c_bit_s;
                end else begin
                    cout_d = cout_q;
                end
            end
            DONE: begin
                sum_d = sum_q;
            end
            default: begin
                sum_d = sum_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            sum_q    <= '0;
            bitcnt_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sum_q    <= sum_d;
            bitcnt_q <= bitcnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Self-checking bench for serial_adder_sequencer: directed table, corner sequences,
// random operands against an arithmetic reference, and an exhaustive WIDTH=1 instance.
module tb_serial_adder_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, cin, cout, overflow;
    logic [7:0] a, b, sum;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, overflow1;
    logic [0:0] a1, b1, sum1;

    serial_adder_sequencer #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    serial_adder_sequencer #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .overflow(overflow1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition; signed overflow from operand/result signs
    task automatic model(input int w, input int unsigned ma, input int unsigned mb,
                         input int unsigned mc, output int unsigned s,
                         output bit co, output bit ov);
        int unsigned t;
        bit sa, sb, sr;
        t  = ma + mb + mc;
        s  = t & ((32'd1 << w) - 32'd1);
        co = ((t >> w) & 32'd1) != 0;
        sa = ((ma >> (w - 1)) & 32'd1) != 0;
        sb = ((mb >> (w - 1)) & 32'd1) != 0;
        sr = ((s  >> (w - 1)) & 32'd1) != 0;
        ov = (sa == sb) && (sr != sa);
    endtask

    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic [7:0] es, input logic eco, input logic eov,
                        input int hold, input bit poke, input string tag);
        int lat;
        @(negedge clk);
        a = ia; b = ib; cin = ic; in_valid = 1'b1; out_ready = (hold == 0);
        chk({tag, "_ready_at_accept"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        chk({tag, "_busy"}, in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (poke && lat == 2) begin
                in_valid = 1'b1; a = ~ia; b = 8'h5A; cin = ~ic;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (!out_valid) chk({tag, "_busy_shift"}, in_ready, 1'b0);
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, eco);
        chk({tag, "_ovf"}, overflow, eov);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, out_valid, 1'b1);
                chk({tag, "_hold_stable"}, {overflow, cout, sum}, {eov, eco, es});
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_valid_drop"}, out_valid, 1'b0);
        chk({tag, "_ready_back"}, in_ready, 1'b1);
    endtask

    task automatic watch_no_valid(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        int unsigned ms;
        bit mco, mov;
        logic [7:0] ra, rb;
        logic rc;
        int lat;

        tbl[0] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_outputs", {overflow, cout, sum}, 10'h000);
        chk("rst_w1", {in_ready1, out_valid1, sum1, cout1, overflow1}, 5'b10000);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].ov,
                 0, 1'b0, $sformatf("tbl%0d", i));
        end

        // Backpressure and ignored in_valid during SHIFT
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 5, 1'b0, "bp");
        run8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 0, 1'b1, "poke");

        // Reset after 4 SHIFT edges
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_sum", sum, 8'h00);
        watch_no_valid("midrst_no_result");
        run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0, 1'b0, "after_rst");

        // Reset on the same edge as an accept
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        chk("rst_accept_idle", in_ready, 1'b1);
        watch_no_valid("rst_accept_no_result");

        // Reset on the same edge as out_ready in DONE
        @(negedge clk);
        a = 8'hC0; b = 8'h80; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("done_rst_reached", out_valid, 1'b1);
        chk("done_rst_pre", {overflow, cout, sum}, {1'b1, 1'b1, 8'h40});
        rst_n = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("done_rst_state", {in_ready, out_valid}, 2'b10);
        chk("done_rst_outputs", {overflow, cout, sum}, 10'h000);

        // Random operands against the arithmetic reference
        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            model(8, ra, rb, rc, ms, mco, mov);
            run8(ra, rb, rc, ms[7:0], mco, mov, int'($urandom_range(0, 2)),
                 1'($urandom), $sformatf("rnd%0d", i));
        end

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = i[2]; b1 = i[1]; cin1 = i[0]; in_valid1 = 1'b1; out_ready1 = 1'b1;
            @(negedge clk);
            in_valid1 = 1'b0;
            chk($sformatf("w1_busy%0d", i), out_valid1, 1'b0);
            @(negedge clk);
            model(1, i[2], i[1], i[0], ms, mco, mov);
            chk($sformatf("w1_valid%0d", i), out_valid1, 1'b1);
            chk($sformatf("w1_result%0d", i), {overflow1, cout1, sum1}, {mov, mco, ms[0]});
            @(negedge clk);
            chk($sformatf("w1_idle%0d", i), {in_ready1, out_valid1}, 2'b10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
